// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host-side UART 8N1 command transmitter and response receiver
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam logic [11:0] BAUD_M1 = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, SEND_HI, SEND_LO} tx_state_t;
    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;

    tx_state_t   tx_state, tx_next;
    logic [7:0]  lo_hold;
    logic [8:0]  tx_shift;
    logic [11:0] tx_baud;
    logic [3:0]  tx_bit;
    logic        tx_done_d;
    logic        accept;
    logic        tx_bit_end;
    logic        tx_frame_end;

    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic [11:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_fall;
    logic        rx_tick;
    logic        rx_last;

    assign accept       = (tx_state == TX_IDLE) && send_cmd;
    assign tx_bit_end   = (tx_baud == BAUD_M1);
    assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_tick = (rx_state == RX_BUSY) && (rx_cnt == 12'd0);
    assign rx_last = rx_tick && (rx_bit == 4'd9);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (send_cmd)     tx_next = SEND_HI;
            SEND_HI: if (tx_frame_end) tx_next = SEND_LO;
            SEND_LO: if (tx_frame_end) tx_next = TX_IDLE;
            default:                   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_fall) rx_next = RX_BUSY;
            RX_BUSY: if (rx_last) rx_next = RX_IDLE;
            default:              rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    // The low byte's start bit is loaded on the same edge the high byte's stop bit ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TX        <= 1'b1;
            lo_hold   <= 8'h00;
            tx_shift  <= 9'h1ff;
            tx_baud   <= 12'd0;
            tx_bit    <= 4'd0;
            tx_done_d <= 1'b0;
            cmd_sent  <= 1'b0;
        end else begin
            tx_done_d <= (tx_state == SEND_LO) && tx_frame_end;
            if (accept) begin
                lo_hold  <= cmd[7:0];
                tx_shift <= {1'b1, cmd[15:8]};
                TX       <= 1'b0;
                tx_baud  <= 12'd0;
                tx_bit   <= 4'd0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_frame_end) begin
                    if (tx_state == SEND_HI) begin
                        tx_shift <= {1'b1, lo_hold};
                        TX       <= 1'b0;
                    end else begin
                        TX <= 1'b1;
                    end
                    tx_baud <= 12'd0;
                    tx_bit  <= 4'd0;
                end else if (tx_bit_end) begin
                    TX       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                    tx_baud  <= 12'd0;
                end else begin
                    tx_baud <= tx_baud + 12'd1;
                end
            end
            if (accept) begin
                cmd_sent <= 1'b0;
            end else if (tx_done_d) begin
                cmd_sent <= 1'b1;
            end
        end
    end

    // Bit 0 is the start-bit sample, bits 1..8 are data, bit 9 is the stop-bit sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= 12'd0;
            rx_bit   <= 4'd0;
            rx_shift <= 8'h00;
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if ((rx_state == RX_IDLE) && rx_fall) begin
                rx_cnt <= HALF_M1;
                rx_bit <= 4'd0;
            end else if (rx_state == RX_BUSY) begin
                if (rx_tick) begin
                    rx_cnt <= BAUD_M1;
                    rx_bit <= rx_bit + 4'd1;
                    if ((rx_bit >= 4'd1) && (rx_bit <= 4'd8)) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                    end
                    if (rx_last) begin
                        resp <= rx_shift;
                    end
                end else begin
                    rx_cnt <= rx_cnt - 12'd1;
                end
            end
            if (rx_last) begin
                resp_rdy <= 1'b1;
            end else if (((rx_state == RX_IDLE) && rx_fall) || accept) begin
                resp_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm
module tb_remote_comm;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loopback = 1'b0;
    logic        cmd_sent;
    logic        tx_w;
    logic [7:0]  resp;
    logic        resp_rdy;

    int checks = 0;
    int failures = 0;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .TX       (tx_w),
        .RX       (loopback ? tx_w : rx_drv),
        .resp     (resp),
        .resp_rdy (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line level of bit i (0..19) of the two-frame command: start, 8 data LSB first, stop.
    function automatic logic frame_bit(input logic [15:0] c, input int i);
        logic [7:0] b;
        int k;
        b = (i < 10) ? c[15:8] : c[7:0];
        k = i % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_check(input logic [15:0] c, input bit extra_pulse);
        tick();
        cmd = c;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        cmd = 16'($urandom);
        chk_bit("cmd_sent_cleared", cmd_sent, 1'b0);
        chk_bit("start_bit_first_cycle", tx_w, 1'b0);
        for (int cyc = 1; cyc <= 321; cyc++) begin
            tick();
            if (extra_pulse && cyc == 99) begin
                cmd = 16'($urandom);
                send_cmd = 1'b1;
            end
            if (cyc == 100) send_cmd = 1'b0;
            if ((cyc % BD) == BD / 2 && cyc < 320)
                chk_bit($sformatf("tx_bit%0d_cmd%h", cyc / BD, c), tx_w, frame_bit(c, cyc / BD));
            if (cyc == 320) chk_bit("cmd_sent_before_321", cmd_sent, 1'b0);
            if (cyc == 321) chk_bit("cmd_sent_at_321", cmd_sent, 1'b1);
        end
        repeat (5) tick();
        chk_bit("cmd_sent_sticky", cmd_sent, 1'b1);
        chk_bit("tx_idle_after_cmd", tx_w, 1'b1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            for (int j = 0; j < BD; j++) begin
                tick();
                if (i == 5 && j == 0) chk_bit("resp_rdy_low_mid_frame", resp_rdy, 1'b0);
            end
        end
        rx_drv = 1'b1;
        repeat (4) tick();
        chk_byte($sformatf("resp_byte_%h", b), resp, b);
        chk_bit("resp_rdy_after_frame", resp_rdy, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] last_b;
        bit seen_hi;
        bit seen_clear;
        int zeros;

        repeat (3) tick();
        chk_bit("rst_tx", tx_w, 1'b1);
        chk_bit("rst_cmd_sent", cmd_sent, 1'b0);
        chk_bit("rst_resp_rdy", resp_rdy, 1'b0);
        chk_byte("rst_resp", resp, 8'h00);
        rst = 1'b0;
        tick();
        chk_bit("post_rst_tx", tx_w, 1'b1);
        chk_bit("post_rst_cmd_sent", cmd_sent, 1'b0);
        chk_bit("post_rst_resp_rdy", resp_rdy, 1'b0);
        chk_byte("post_rst_resp", resp, 8'h00);

        send_check(16'h4A24, 1'b1);
        for (int n = 0; n < 3; n++) send_check(16'($urandom), 1'b0);

        rx_frame(8'hA5, 1'b1);
        last_b = 8'hA5;
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            rx_frame(rb, (n == 2) ? 1'b0 : 1'b1);
            last_b = rb;
        end

        tick();
        cmd = 16'($urandom);
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        chk_bit("resp_rdy_cleared_by_send", resp_rdy, 1'b0);
        chk_byte("resp_kept_on_send", resp, last_b);
        repeat (340) tick();

        loopback = 1'b1;
        seen_hi = 1'b0;
        seen_clear = 1'b0;
        tick();
        cmd = 16'h0F3C;
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        for (int cyc = 1; cyc <= 340; cyc++) begin
            tick();
            if (resp_rdy && resp == 8'h0F) seen_hi = 1'b1;
            if (seen_hi && !resp_rdy) seen_clear = 1'b1;
        end
        chk_bit("loop_saw_0F", seen_hi, 1'b1);
        chk_bit("loop_cleared_between", seen_clear, 1'b1);
        chk_byte("loop_resp_3C", resp, 8'h3C);
        chk_bit("loop_resp_rdy", resp_rdy, 1'b1);
        chk_bit("loop_cmd_sent", cmd_sent, 1'b1);
        loopback = 1'b0;

        tick();
        cmd = 16'($urandom);
        send_cmd = 1'b1;
        tick();
        send_cmd = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        chk_bit("midrst_tx", tx_w, 1'b1);
        chk_bit("midrst_cmd_sent", cmd_sent, 1'b0);
        chk_bit("midrst_resp_rdy", resp_rdy, 1'b0);
        tick();
        rst = 1'b0;
        zeros = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (tx_w !== 1'b1) zeros++;
        end
        chk_byte("midrst_no_more_bits", 8'(zeros), 8'd0);
        chk_bit("midrst_cmd_sent_low", cmd_sent, 1'b0);
        send_check(16'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
